// File: rtl/mult_operand_sequencer.sv
// Flow-controlled front end for the 4-bit repeated-addition multiplier: FIFO-buffered operand pairs,
// serialised onto start/data_in, product returned on a valid/ready port. Optional watchdog: MULT_SEQ_TIMEOUT_EN.
module mult_operand_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       start,
    output logic [3:0] data_in,
    input  logic       done,
    input  logic [7:0] result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic [7:0] out_product,
    output logic       busy,
    output logic       timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, WAIT} state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } pair_t;

    pair_t         mem [FIFO_DEPTH];
    pair_t         head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          capture;
    logic          timeout_hit;
    logic [3:0]    cur_a;
    logic [3:0]    cur_b;
    state_t        state;
    state_t        next_state;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign in_ready = reset && !full;
    assign push  = in_valid && in_ready;
    assign head  = mem[rd_ptr[AW-1:0]];
    assign busy  = (state != IDLE) || !empty;

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= pair_t'{a: in_a, b: in_b};
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && (!out_valid || out_ready)) begin
                    next_state = SEND_A;
                    pop        = 1'b1;
                end
            end
            SEND_A: next_state = SEND_B;
            SEND_B: next_state = WAIT;
            WAIT: begin
                if (done) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cur_a       <= '0;
            cur_b       <= '0;
            start       <= 1'b0;
            data_in     <= '0;
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_product <= '0;
        end else begin
            state <= next_state;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cur_a  <= head.a;
                cur_b  <= head.b;
            end
            start <= (next_state == SEND_A);
            case (next_state)
                SEND_A:  data_in <= head.a;
                SEND_B:  data_in <= cur_b;
                default: data_in <= '0;
            endcase
            if (capture) begin
                out_valid   <= 1'b1;
                out_a       <= cur_a;
                out_b       <= cur_b;
                out_product <= result;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MULT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    // Counter holds the number of completed WAIT cycles; it fires on the TIMEOUT_CYCLES-th edge.
    assign timeout_hit = (state == WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit && !done;
            if ((state == WAIT) && (next_state == WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    // Always false; the limit is only meaningful when the watchdog is built.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/mult_operand_sequencer.md
# mult_operand_sequencer

Upstream feeder for the 4-bit repeated-addition multiplier. It accepts operand pairs on a valid/ready port and buffers them in a small FIFO. It serialises each pair onto the multiplier's `start`/`data_in` protocol, waits for `done`, and returns the captured 8-bit product with its operands on a valid/ready output port. Within the multiplier environment it takes the place of the driver-side stimulus path and gives the bench a flow-controlled, transaction-level front end.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4 — operand FIFO entries; must be a power of 2, at least 2.
- `TIMEOUT_CYCLES`, default 32 — watchdog limit in WAIT. Used only with `MULT_SEQ_TIMEOUT_EN`.

Ports:
- Clocking and reset (already decided): one clock, `clock`. Reset is `reset`, asynchronous and active-low.
- `clock`  in  1  — system clock; all state updates on its rising edge.
- `reset`  in  1  — asynchronous active-low reset; `0` clears all state immediately.
- `in_valid`  in  1  — operand pair valid.
- `in_ready`  out  1  — FIFO not full.
- `in_a`  in  4  — multiplicand.
- `in_b`  in  4  — multiplier.
- `start`  out  1  — launch pulse to the multiplier.
- `data_in`  out  4  — serial operand bus to the multiplier.
- `done`  in  1  — multiplier completion pulse.
- `result`  in  8  — multiplier product; sampled only when `done`=1.
- `out_valid`  out  1  — product available.
- `out_ready`  in  1  — consumer accepts the product.
- `out_a`, `out_b`  out  4 each  — operands that produced `out_product`.
- `out_product`  out  8  — captured product.
- `busy`  out  1  — 1 whenever FSM≠IDLE or FIFO non-empty.
- `timeout_err`  out  1  — watchdog pulse; constant 0 when the feature is compiled out.

## Operation
- Input push occurs when `in_valid && in_ready`. `in_ready` = !full. There is no bypass: when full, `in_ready`=0 even if a pop happens in the same cycle.
- Output register holds one entry. It is loaded on the `done` capture and cleared when `out_valid && out_ready`.
- IDLE:
  - Go to SEND_A when the FIFO is non-empty and (`out_valid`=0 or the output is draining this cycle).
  - Pop the FIFO head into the `cur_a`/`cur_b` registers on that transition.
- SEND_A: `start`=1, `data_in`=`cur_a`. Always goes to SEND_B.
- SEND_B: `start`=0, `data_in`=`cur_b`. Always goes to WAIT.
- WAIT: `data_in`=0.
  - On `done`=1: capture `result` → `out_product` and `cur_a`/`cur_b` → `out_a`/`out_b`, set `out_valid`=1, go to IDLE.
- `done` seen in IDLE, SEND_A or SEND_B is ignored.
- The product is not checked or altered; the sequencer is transparent to arithmetic.
- Simultaneous push and pop: both take effect; the count is unchanged.
- FIFO pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally. Full/empty are derived from the pointer MSB.
- Reset mid-operation:
  - FIFO is emptied and the in-flight pair is discarded; no output is produced for it.
  - Reset values: `start`=0, `data_in`=0, `out_valid`=0, `out_a`=`out_b`=0, `out_product`=0, `busy`=0, `timeout_err`=0.
  - `in_ready` is forced to 0 while `reset`=0 and reads 1 from the first cycle after release.

## Timing
- Outputs `start`, `data_in`, `out_*` and `timeout_err` are registered.
- Pair accepted at edge k, FIFO and FSM idle:
  - `start`=1 with `data_in`=A in the cycle after edge k+1.
  - `data_in`=B in the following cycle.
- Done sampled at edge m: `out_valid`=1 from edge m.
- The next `start` can occur no earlier than 2 cycles after the capture edge, and only if the output slot was freed.
- Back-pressure: if `out_ready` is held at 0, the pipeline stalls in IDLE after one completed product. The FIFO keeps accepting until full.

## Configuration
- Macro: `MULT_SEQ_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT. If it reaches `TIMEOUT_CYCLES` without `done`, `timeout_err` pulses 1 for one cycle.
  - The pair is dropped with no output, and the FSM returns to IDLE.
  - A `done` arriving in that same cycle wins: the product is captured and no error is raised.
- Not defined: no counter, `timeout_err` tied 0, and WAIT waits indefinitely.

## Test plan
- Single pair: A=7, B=9, `done` returned 12 cycles after `start`, `result`=63.
  - Expect: `start` pulse with `data_in`=7, then `data_in`=9.
  - Expect: `out_valid` with `out_product`=63, `out_a`=7, `out_b`=9.
- Burst of 5 pairs with `FIFO_DEPTH`=4 while the multiplier stalls:
  - Expect: `in_ready` falls after 4 accepts, or 5 if one pair has already popped.
  - Expect: all products emerge in order; 15×15 → 225.
- `out_ready` held 0 across two completions:
  - Expect: second `start` is not issued until the first product drains.
  - Expect: no product lost or overwritten.
- Spurious `done` while IDLE or in SEND_B:
  - Expect: ignored; `out_valid` stays 0 until the real `done` in WAIT.
- Reset asserted in WAIT with 2 pairs queued:
  - Expect: outputs go to reset values immediately; after release `busy`=0.
  - Expect: no `out_valid` and no `start` until new input arrives.
- With `MULT_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=32, `done` never returned:
  - Expect: `timeout_err`=1 for exactly one cycle, 32 cycles after entering WAIT.
  - Expect: the next queued pair launches afterwards.
